// File: rtl/bram_frame_buffer.sv
// Dual-port pixel frame buffer in inferred block RAM with a clear engine and out-of-range handling.
// Optional page flipping is compiled in with `define DOUBLE_BUFFER_EN.
module bram_frame_buffer #(
    parameter int unsigned      WIDTH     = 128,
    parameter int unsigned      HEIGHT    = 128,
    parameter int unsigned      PIX_W     = 16,
    parameter logic [PIX_W-1:0] CLEAR_VAL = '0,
    parameter logic [PIX_W-1:0] OOR_VAL   = '0,
    localparam int unsigned     XW        = $clog2(WIDTH),
    localparam int unsigned     YW        = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [XW-1:0]    wr_x,
    input  logic [YW-1:0]    wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [XW-1:0]    rd_x,
    input  logic [YW-1:0]    rd_y,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clear_start,
    output logic             busy,
    output logic             clear_done,
    input  logic             swap_req,
    input  logic             frame_start,
    output logic             front_page
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;
    localparam int unsigned AW    = $clog2(DEPTH);
`ifdef DOUBLE_BUFFER_EN
    localparam int unsigned RAM_AW    = AW + 1;
    localparam int unsigned RAM_DEPTH = 2 * (1 << AW);
`else
    localparam int unsigned RAM_AW    = AW;
    localparam int unsigned RAM_DEPTH = DEPTH;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [AW-1:0]     clr_cnt;
    logic [AW-1:0]     wr_lin, rd_lin;
    logic              wr_in, rd_in;
    logic [RAM_AW-1:0] wr_addr, rd_addr, clr_addr;
    logic [PIX_W-1:0]  mem [RAM_DEPTH];

    assign wr_in  = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign rd_in  = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
    assign wr_lin = AW'(wr_y) * AW'(WIDTH) + AW'(wr_x);
    assign rd_lin = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

`ifdef DOUBLE_BUFFER_EN
    logic swap_pend;

    // Producer side (writes, clear) always targets the page not being scanned out.
    assign wr_addr  = {~front_page, wr_lin};
    assign clr_addr = {~front_page, clr_cnt};
    assign rd_addr  = {front_page, rd_lin};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_page <= 1'b0;
            swap_pend  <= 1'b0;
        end else if (frame_start && (swap_pend || swap_req) && !busy) begin
            front_page <= ~front_page;
            swap_pend  <= 1'b0;
        end else if (swap_req) begin
            swap_pend  <= 1'b1;
        end
    end
`else
    logic unused_swap;

    assign wr_addr     = wr_lin;
    assign clr_addr    = clr_cnt;
    assign rd_addr     = rd_lin;
    assign front_page  = 1'b0;
    assign unused_swap = swap_req ^ frame_start;
`endif

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= CLEAR_VAL;
        end else if (wr_en && wr_in) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem gives read-first behaviour on a same-address write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in ? mem[rd_addr] : OOR_VAL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                        clr_cnt    <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_frame_buffer.sv
// Directed bench for bram_frame_buffer: a 128x128 instance (clear/reset tests) and a 100-wide instance
// (out-of-range handling).
module tb_bram_frame_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_wr_en, a_rd_en, a_clear_start, a_swap_req, a_frame_start;
    logic [6:0]  a_wr_x, a_wr_y, a_rd_x, a_rd_y;
    logic [15:0] a_wr_data, a_rd_data;
    logic        a_rd_valid, a_busy, a_clear_done, a_front_page;

    logic        b_wr_en, b_rd_en, b_clear_start, b_swap_req, b_frame_start;
    logic [6:0]  b_wr_x, b_wr_y, b_rd_x, b_rd_y;
    logic [15:0] b_wr_data, b_rd_data;
    logic        b_rd_valid, b_busy, b_clear_done, b_front_page;

    bram_frame_buffer #(
        .WIDTH(128), .HEIGHT(128), .PIX_W(16), .CLEAR_VAL(16'h001F), .OOR_VAL(16'hF81F)
    ) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .clear_start(a_clear_start), .busy(a_busy), .clear_done(a_clear_done),
        .swap_req(a_swap_req), .frame_start(a_frame_start), .front_page(a_front_page)
    );

    bram_frame_buffer #(
        .WIDTH(100), .HEIGHT(128), .PIX_W(16), .CLEAR_VAL(16'h0000), .OOR_VAL(16'hF81F)
    ) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .clear_start(b_clear_start), .busy(b_busy), .clear_done(b_clear_done),
        .swap_req(b_swap_req), .frame_start(b_frame_start), .front_page(b_front_page)
    );

    typedef struct {
        bit          sel;   // 0: dut_a, 1: dut_b
        bit          we;
        logic [6:0]  wx, wy;
        logic [15:0] wd;
        bit          re;
        logic [6:0]  rx, ry;
        bit          ev;
        logic [15:0] ed;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_wr_en = 0; a_rd_en = 0; a_clear_start = 0; a_swap_req = 0; a_frame_start = 0;
        b_wr_en = 0; b_rd_en = 0; b_clear_start = 0; b_swap_req = 0; b_frame_start = 0;
    endtask

    task automatic wr_a(input logic [6:0] x, input logic [6:0] y, input logic [15:0] d);
        @(negedge clk);
        a_wr_en = 1; a_wr_x = x; a_wr_y = y; a_wr_data = d;
        tick();
        a_wr_en = 0;
    endtask

    task automatic rd_a(input string name, input logic [6:0] x, input logic [6:0] y, input logic [15:0] e);
        @(negedge clk);
        a_rd_en = 1; a_rd_x = x; a_rd_y = y;
        tick();
        a_rd_en = 0;
        check(name, {15'd0, a_rd_valid, a_rd_data}, {15'd0, 1'b1, e});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int busy_n;
        int dones;
        int n;

        vt[0]  = '{0, 1,   5,   3, 16'hABCD, 0,   0,   0, 0, 16'h0000};
        vt[1]  = '{0, 0,   0,   0, 16'h0000, 1,   5,   3, 1, 16'hABCD};
        vt[2]  = '{0, 1,   0,   0, 16'h2222, 0,   0,   0, 0, 16'hABCD};
        vt[3]  = '{0, 1,   0,   0, 16'h1111, 1,   0,   0, 1, 16'h2222};
        vt[4]  = '{0, 0,   0,   0, 16'h0000, 1,   0,   0, 1, 16'h1111};
        vt[5]  = '{0, 1, 127, 127, 16'hBEEF, 1,   5,   3, 1, 16'hABCD};
        vt[6]  = '{0, 1, 127, 126, 16'h1234, 1, 127, 127, 1, 16'hBEEF};
        vt[7]  = '{0, 0,   0,   0, 16'h0000, 0,   0,   0, 0, 16'hBEEF};
        vt[8]  = '{0, 1,   3,   5, 16'h5555, 1, 127, 126, 1, 16'h1234};
        vt[9]  = '{0, 0,   0,   0, 16'h0000, 1,   3,   5, 1, 16'h5555};
        vt[10] = '{0, 0,   0,   0, 16'h0000, 1,   5,   3, 1, 16'hABCD};
        vt[11] = '{1, 1,  20,   1, 16'hA5A5, 0,   0,   0, 0, 16'h0000};
        vt[12] = '{1, 0,   0,   0, 16'h0000, 1, 120,   0, 1, 16'hF81F};
        vt[13] = '{1, 1, 120,   0, 16'hDEAD, 0,   0,   0, 0, 16'hF81F};
        vt[14] = '{1, 1,  99,   0, 16'h7777, 1,  20,   1, 1, 16'hA5A5};
        vt[15] = '{1, 1,   0,   1, 16'h0101, 1,  99,   0, 1, 16'h7777};
        vt[16] = '{1, 0,   0,   0, 16'h0000, 1,   0,   1, 1, 16'h0101};
        vt[17] = '{1, 0,   0,   0, 16'h0000, 1, 100, 127, 1, 16'hF81F};
        vt[18] = '{1, 0,   0,   0, 16'h0000, 1,  20,   1, 1, 16'hA5A5};

        idle_all();
        a_wr_x = 0; a_wr_y = 0; a_wr_data = 0; a_rd_x = 0; a_rd_y = 0;
        b_wr_x = 0; b_wr_y = 0; b_wr_data = 0; b_rd_x = 0; b_rd_y = 0;
        reset = 1;
        repeat (3) tick();
        @(negedge clk);
        reset = 0;
        tick();

        check("reset_a_outputs", {a_rd_valid, a_busy, a_clear_done, a_front_page, a_rd_data}, 32'h0);
        check("reset_b_outputs", {b_rd_valid, b_busy, b_clear_done, b_front_page, b_rd_data}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            idle_all();
            if (vt[i].sel == 0) begin
                a_wr_en = vt[i].we; a_wr_x = vt[i].wx; a_wr_y = vt[i].wy; a_wr_data = vt[i].wd;
                a_rd_en = vt[i].re; a_rd_x = vt[i].rx; a_rd_y = vt[i].ry;
            end else begin
                b_wr_en = vt[i].we; b_wr_x = vt[i].wx; b_wr_y = vt[i].wy; b_wr_data = vt[i].wd;
                b_rd_en = vt[i].re; b_rd_x = vt[i].rx; b_rd_y = vt[i].ry;
            end
            tick();
            if (vt[i].sel == 0) begin
                check($sformatf("vec%0d_valid", i), {31'd0, a_rd_valid}, {31'd0, vt[i].ev});
                check($sformatf("vec%0d_data", i), {16'd0, a_rd_data}, {16'd0, vt[i].ed});
            end else begin
                check($sformatf("vec%0d_valid", i), {31'd0, b_rd_valid}, {31'd0, vt[i].ev});
                check($sformatf("vec%0d_data", i), {16'd0, b_rd_data}, {16'd0, vt[i].ed});
            end
        end
        @(negedge clk);
        idle_all();

        // Full clear: mid-clear read of an untouched pixel, ignored write and ignored re-start.
        @(negedge clk);
        a_clear_start = 1;
        tick();
        check("clr_busy_rise", {31'd0, a_busy}, 32'd1);
        busy_n = a_busy ? 1 : 0;
        dones  = a_clear_done ? 1 : 0;
        n = 0;
        while (a_busy && n < 20000) begin
            @(negedge clk);
            a_clear_start = (n == 2000);
            a_wr_en = (n == 1000); a_wr_x = 5; a_wr_y = 3; a_wr_data = 16'h9999;
            a_rd_en = (n == 10); a_rd_x = 127; a_rd_y = 127;
            tick();
            if (n == 10) check("clr_mid_read", {15'd0, a_rd_valid, a_rd_data}, {15'd0, 1'b1, 16'hBEEF});
            if (a_busy) busy_n++;
            if (a_clear_done) dones++;
            n++;
        end
        @(negedge clk);
        idle_all();
        check("clr_busy_cycles", busy_n, 16384);
        check("clr_done_at_end", {31'd0, a_clear_done}, 32'd1);
        repeat (2) begin
            tick();
            if (a_clear_done) dones++;
        end
        check("clr_done_pulses", dones, 1);
        rd_a("clr_corner_00", 0, 0, 16'h001F);
        rd_a("clr_corner_127", 127, 127, 16'h001F);
        rd_a("clr_ignored_write", 5, 3, 16'h001F);

        // Reset in the middle of a clear at clr_cnt==500.
        wr_a(0, 1, 16'hAAAA);
        wr_a(115, 3, 16'hEEEE);
        wr_a(116, 3, 16'hDDDD);
        wr_a(120, 4, 16'hCCCC);
        @(negedge clk);
        a_clear_start = 1;
        tick();
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            a_clear_start = 0;
            a_rd_en = (k == 499); a_rd_x = 0; a_rd_y = 0;
            tick();
        end
        check("rst_pre_state", {30'd0, a_busy, a_rd_valid}, 32'd3);
        #1 reset = 1;
        #1;
        check("rst_async_outputs", {a_rd_valid, a_busy, a_clear_done, a_rd_data}, 32'h0);
        @(negedge clk);
        a_rd_en = 0;
        reset = 0;
        rd_a("rst_partial_128", 0, 1, 16'h001F);
        rd_a("rst_partial_499", 115, 3, 16'h001F);
        rd_a("rst_partial_500", 116, 3, 16'hDDDD);
        rd_a("rst_partial_632", 120, 4, 16'hCCCC);

        wr_a(0, 0, 16'h4444);
        @(negedge clk);
        a_clear_start = 1;
        tick();
        @(negedge clk);
        a_clear_start = 0;
        repeat (3) tick();
        rd_a("restart_from_0", 0, 0, 16'h001F);
        check("restart_busy", {31'd0, a_busy}, 32'd1);
        #1 reset = 1;
        #1;
        check("restart_abort", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        reset = 0;

`ifdef DOUBLE_BUFFER_EN
        wr_a(1, 1, 16'h07E0);
        @(negedge clk);
        a_swap_req = 1;
        tick();
        @(negedge clk);
        a_swap_req = 0;
        tick();
        check("swap_pending_only", {31'd0, a_front_page}, 32'd0);
        @(negedge clk);
        a_frame_start = 1;
        tick();
        @(negedge clk);
        a_frame_start = 0;
        check("swap_front_page", {31'd0, a_front_page}, 32'd1);
        rd_a("swap_read", 1, 1, 16'h07E0);
`else
        @(negedge clk);
        a_swap_req = 1; a_frame_start = 1;
        tick();
        @(negedge clk);
        a_swap_req = 0; a_frame_start = 0;
        check("single_page_swap_together", {31'd0, a_front_page}, 32'd0);
        @(negedge clk);
        a_swap_req = 1;
        tick();
        @(negedge clk);
        a_swap_req = 0; a_frame_start = 1;
        tick();
        @(negedge clk);
        a_frame_start = 0;
        check("single_page_swap_later", {31'd0, a_front_page}, 32'd0);
        rd_a("single_page_read", 0, 0, 16'h001F);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
